// File: rtl/sw_line_pkg.sv
// Shared types and default constants for the single-wire line receiver.
package sw_line_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/line_sync.sv
// Two-flop synchronizer for the shared line; anything other than a driven 0 reads as 1.
module line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_s
);

    logic d;
    logic meta;

    // A released (z) or unknown (x) line is treated as the pulled-up level.
    always_comb begin
        d = (line_in === 1'b0) ? 1'b0 : 1'b1;
    end

    // Synchronizer chain, resetting to the idle (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            line_s <= 1'b1;
        end else begin
            meta   <= d;
            line_s <= meta;
        end
    end

endmodule

// File: rtl/sw_line_receiver.sv
// Single-wire serial line receiver: start/data/stop framing, valid/ready output stage.
module sw_line_receiver
    import sw_line_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 line_s;
    logic                 sample_pt;
    logic                 frame_ok;

    line_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (line_in),
        .line_s  (line_s)
    );

    // Mid-bit sample strobe and good-stop-bit detection.
    always_comb begin
        sample_pt = (cnt == FULL_M1);
        frame_ok  = (state == STOP) && sample_pt && line_s;
    end

    // Framing FSM with bit counter, bit index, shift register and error/busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!line_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!line_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (sample_pt) begin
                        cnt   <= '0;
                        shreg <= {line_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (sample_pt) begin
                        cnt <= '0;
                        if (line_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (line_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: a completed frame loads unless the held byte is still unconsumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_ok) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
